// File: rtl/pwm_capture.sv
// rtl/pwm_capture.sv - single-channel PWM period/high-time decoder with AXI-Stream sample output

module pwm_capture #(
    parameter int          CNT_WIDTH          = 16,
    parameter int          FILTER_LEN         = 3,
    parameter int unsigned TIMEOUT            = 16'hFFFF,
    parameter bit          INPUT_ACTIVE_LEVEL = 1'b1
) (
    input  logic                   clk,
    input  logic                   rstn,
    input  logic                   pwm_in,
    output logic [2*CNT_WIDTH-1:0] m_axis_tdata,
    output logic                   m_axis_tvalid,
    input  logic                   m_axis_tready,
    output logic                   level_out,
    output logic                   timeout,
    output logic                   overrun
);

    // Pin level that maps to act=0; the synchronizer resets to it so a
    // freshly reset block sees an inactive input on either polarity.
    localparam logic ACT_INV  = (INPUT_ACTIVE_LEVEL == 1'b0);
    localparam logic IDLE_PIN = ACT_INV;

    // Filter run counter only needs to count up to FILTER_LEN-1.
    localparam int                RUN_W    = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
    localparam logic [RUN_W-1:0]  RUN_LAST = RUN_W'(FILTER_LEN - 1);

    localparam logic [CNT_WIDTH-1:0] TIMEOUT_CNT = CNT_WIDTH'(TIMEOUT);
    localparam logic [CNT_WIDTH-1:0] CNT_ONE     = CNT_WIDTH'(1);

    localparam logic [0:0] ST_IDLE    = 1'b0;
    localparam logic [0:0] ST_MEASURE = 1'b1;

    logic                 sync_1;
    logic                 sync_2;
    logic                 act;
    logic                 lvl;
    logic                 lvl_d;
    logic [RUN_W-1:0]     run_cnt;
    logic                 rise;
    logic                 fall;

    logic [0:0]           state;
    logic [CNT_WIDTH-1:0] p_cnt;
    logic [CNT_WIDTH-1:0] h_cnt;
    logic [CNT_WIDTH-1:0] h_lat;
    logic                 fall_seen;
    logic                 timeout_r;

    logic                 emit;
    logic [2*CNT_WIDTH-1:0] emit_data;

    logic [2*CNT_WIDTH-1:0] tdata_r;
    logic                   tvalid_r;
    logic                   overrun_r;

    // Two-flop synchronizer for the asynchronous PWM pin.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            sync_1 <= IDLE_PIN;
            sync_2 <= IDLE_PIN;
        end else begin
            sync_1 <= pwm_in;
            sync_2 <= sync_1;
        end
    end

    assign act = sync_2 ^ ACT_INV;

    // Glitch filter: accept a new level only after FILTER_LEN consecutive
    // disagreeing samples; any agreeing sample restarts the run.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            lvl     <= 1'b0;
            run_cnt <= '0;
        end else if (act == lvl) begin
            run_cnt <= '0;
        end else if (run_cnt == RUN_LAST) begin
            lvl     <= act;
            run_cnt <= '0;
        end else begin
            run_cnt <= run_cnt + RUN_W'(1);
        end
    end

    // Delayed filtered level for edge detection.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            lvl_d <= 1'b0;
        end else begin
            lvl_d <= lvl;
        end
    end

    assign rise = lvl & ~lvl_d;
    assign fall = ~lvl & lvl_d;

    // A sample exists only when a full period (rise, fall, rise) was seen.
    assign emit      = (state == ST_MEASURE) && rise && fall_seen;
    assign emit_data = {h_lat, p_cnt};

    // Measurement state machine: counters are loaded to 1 on a rise so that
    // a period of T filtered cycles reads back as exactly T.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state     <= ST_IDLE;
            p_cnt     <= '0;
            h_cnt     <= '0;
            h_lat     <= '0;
            fall_seen <= 1'b0;
            timeout_r <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (rise) begin
                        state     <= ST_MEASURE;
                        p_cnt     <= CNT_ONE;
                        h_cnt     <= CNT_ONE;
                        fall_seen <= 1'b0;
                        timeout_r <= 1'b0;
                    end
                end
                ST_MEASURE: begin
                    if (rise) begin
                        // Rise without a prior fall cannot survive the filter;
                        // it is handled as a plain reload.
                        p_cnt     <= CNT_ONE;
                        h_cnt     <= CNT_ONE;
                        fall_seen <= 1'b0;
                        timeout_r <= 1'b0;
                    end else if (p_cnt == TIMEOUT_CNT) begin
                        state     <= ST_IDLE;
                        timeout_r <= 1'b1;
                    end else begin
                        p_cnt <= p_cnt + CNT_ONE;
                        if (!fall_seen) begin
                            h_cnt <= h_cnt + CNT_ONE;
                        end
                        if (fall) begin
                            h_lat     <= h_cnt;
                            fall_seen <= 1'b1;
                        end
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    // Output register: one-deep AXIS slot; a sample arriving while the
    // previous beat is stalled is dropped and flagged, never overwritten.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            tdata_r   <= '0;
            tvalid_r  <= 1'b0;
            overrun_r <= 1'b0;
        end else begin
            overrun_r <= 1'b0;
            if (emit) begin
                if (!tvalid_r || m_axis_tready) begin
                    tdata_r  <= emit_data;
                    tvalid_r <= 1'b1;
                end else begin
                    overrun_r <= 1'b1;
                end
            end else if (m_axis_tready) begin
                tvalid_r <= 1'b0;
            end
        end
    end

    assign m_axis_tdata  = tdata_r;
    assign m_axis_tvalid = tvalid_r;
    assign level_out     = lvl;
    assign timeout       = timeout_r;
    assign overrun       = overrun_r;

endmodule

// File: tb/tb_pwm_capture.sv
// tb/tb_pwm_capture.sv - self-checking bench for pwm_capture with a segment-level reference model

module tb_pwm_capture;

    localparam int CW = 16;
    localparam int FL = 3;
    localparam int TO = 4096;

    logic          clk = 1'b0;
    logic          rstn = 1'b0;
    logic          pwm = 1'b0;
    logic          pwm_n;
    logic          tready = 1'b0;

    logic [31:0]   tdata;
    logic          tvalid;
    logic          lvl_o;
    logic          to_o;
    logic          ov;
    logic [31:0]   inv_tdata;
    logic          inv_tvalid;
    logic          inv_lvl;
    logic          inv_to;
    logic          inv_ov;

    assign pwm_n = ~pwm;

    always #5 clk = ~clk;

    pwm_capture #(.CNT_WIDTH(CW), .FILTER_LEN(FL), .TIMEOUT(TO), .INPUT_ACTIVE_LEVEL(1'b1)) u_dut (
        .clk(clk), .rstn(rstn), .pwm_in(pwm),
        .m_axis_tdata(tdata), .m_axis_tvalid(tvalid), .m_axis_tready(tready),
        .level_out(lvl_o), .timeout(to_o), .overrun(ov)
    );

    pwm_capture #(.CNT_WIDTH(CW), .FILTER_LEN(FL), .TIMEOUT(TO), .INPUT_ACTIVE_LEVEL(1'b0)) u_inv (
        .clk(clk), .rstn(rstn), .pwm_in(pwm_n),
        .m_axis_tdata(inv_tdata), .m_axis_tvalid(inv_tvalid), .m_axis_tready(tready),
        .level_out(inv_lvl), .timeout(inv_to), .overrun(inv_ov)
    );

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    // Reference model state: filtered level, time since last accepted rise,
    // high time of the current period, expected beats and drop count.
    logic        mlvl = 1'b0;
    bit          have_rise = 0;
    bit          have_fall = 0;
    int          t = 0;
    int          ht = 0;
    logic [31:0] expq[$];
    logic [31:0] last_push = '0;
    int          exp_ov = 0;
    bit          hs_flag = 0;

    int          ov_seen = 0;
    int          inv_ov_seen = 0;
    int          beats = 0;
    int          first_valid_cyc = -1;
    bit          prev_hold = 0;
    logic [31:0] prev_data = '0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_push(input logic [31:0] b);
        last_push = b;
        if (!hs_flag && !tready && expq.size() > 0) exp_ov++;
        else expq.push_back(b);
    endtask

    // A pin segment shorter than the filter length never moves the filtered
    // level; a long segment of the other level moves it at its start.
    task automatic model_edge(input logic lv, input int len);
        if (len >= FL && lv != mlvl) begin
            if (lv) begin
                if (have_rise && have_fall && t <= TO) model_push({ht[15:0], t[15:0]});
                have_rise = 1;
                have_fall = 0;
                t = 0;
            end else begin
                ht = t;
                have_fall = 1;
            end
            mlvl = lv;
        end
    endtask

    task automatic model_reset();
        mlvl = 1'b0;
        have_rise = 0;
        have_fall = 0;
        t = 0;
        expq.delete();
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge clk);
        t += n;
    endtask

    task automatic seg(input logic lv, input int len);
        model_edge(lv, len);
        pwm = lv;
        wait_cyc(len);
    endtask

    // Beat monitor: compares accepted beats with the model and checks that a
    // stalled beat is held stable.
    always @(negedge clk) begin
        #1;
        if (ov) ov_seen++;
        if (inv_ov) inv_ov_seen++;
        if (rstn) begin
            if (tvalid && first_valid_cyc < 0) first_valid_cyc = cyc;
            if (prev_hold) begin
                chk("hold_valid", 32'(tvalid), 32'd1);
                chk("hold_data", tdata, prev_data);
            end
            if (tvalid && tready) begin
                beats++;
                checks++;
                assert (expq.size() != 0) else begin
                    errors++;
                    $error("FAIL spurious_beat: observed %0h expected no beat", tdata);
                end
                if (expq.size() != 0) begin
                    logic [31:0] e;
                    e = expq.pop_front();
                    chk("beat_data", tdata, e);
                    chk("inv_beat_data", inv_tdata, e);
                    chk("inv_beat_valid", 32'(inv_tvalid), 32'd1);
                end
            end
        end
        prev_hold = rstn && tvalid && !tready;
        prev_data = tdata;
    end

    initial begin
        int c0;
        int b0;
        int h;
        int a;
        int g;
        logic [31:0] expc;

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_tdata", tdata, 32'd0);
        chk("rst_tvalid", 32'(tvalid), 32'd0);
        chk("rst_level", 32'(lvl_o), 32'd0);
        chk("rst_timeout", 32'(to_o), 32'd0);
        chk("rst_overrun", 32'(ov), 32'd0);
        chk("rst_inv_level", 32'(inv_lvl), 32'd0);
        rstn = 1'b1;
        model_reset();

        // Basic measurement: 5 periods of 1000 with 250 high
        tready = 1'b1;
        first_valid_cyc = -1;
        b0 = beats;
        seg(1'b1, 250); seg(1'b0, 750);
        c0 = cyc;
        for (int i = 0; i < 4; i++) begin
            seg(1'b1, 250); seg(1'b0, 750);
        end
        chk("basic_latency", 32'(first_valid_cyc - c0), 32'd6);
        chk("basic_beats", 32'(beats - b0), 32'd4);

        // Glitch filter: 2-cycle low glitches are ignored, a 3-cycle one is not
        for (int i = 0; i < 3; i++) begin
            seg(1'b1, 100); seg(1'b0, 2); seg(1'b1, 148); seg(1'b0, 750);
        end
        seg(1'b1, 100); seg(1'b0, 3); seg(1'b1, 147); seg(1'b0, 750);
        seg(1'b1, 250); seg(1'b0, 750);

        // Randomized periods with occasional short glitches in the high time
        for (int i = 0; i < 40; i++) begin
            h = $urandom_range(12, 60);
            if ($urandom_range(0, 1) == 1) begin
                a = $urandom_range(4, h - 6);
                g = $urandom_range(1, 2);
                seg(1'b1, a); seg(1'b0, g); seg(1'b1, h - a - g);
            end else begin
                seg(1'b1, h);
            end
            seg(1'b0, $urandom_range(4, 60));
        end
        chk("random_overrun", 32'(ov_seen), 32'(exp_ov));

        // Timeout: hold high after a rising edge
        model_edge(1'b1, 4300);
        pwm = 1'b1;
        wait_cyc(20);
        b0 = beats;
        wait_cyc(4080);
        chk("timeout_early", 32'(to_o), 32'd0);
        wait_cyc(3);
        chk("timeout_set", 32'(to_o), 32'd1);
        chk("timeout_level", 32'(lvl_o), 32'd1);
        chk("inv_timeout_set", 32'(inv_to), 32'd1);
        wait_cyc(197);
        chk("timeout_no_beat", 32'(beats - b0), 32'd0);
        seg(1'b0, 750);
        model_edge(1'b1, 250);
        pwm = 1'b1;
        wait_cyc(7);
        chk("timeout_clear", 32'(to_o), 32'd0);
        wait_cyc(243);
        seg(1'b0, 750);
        chk("post_timeout_no_beat", 32'(beats - b0), 32'd0);
        seg(1'b1, 250); seg(1'b0, 750);
        chk("post_timeout_beat", 32'(beats - b0), 32'd1);

        // Backpressure: first beat held, second dropped with one overrun pulse
        tready = 1'b0;
        seg(1'b1, 250); seg(1'b0, 750);
        seg(1'b1, 250); seg(1'b0, 300);
        chk("bp_overrun", 32'(ov_seen), 32'(exp_ov));
        chk("bp_valid_held", 32'(tvalid), 32'd1);
        tready = 1'b1;
        wait_cyc(1);
        chk("bp_release", 32'(tvalid), 32'd0);
        wait_cyc(449);

        // Handshake and emit in the same cycle
        tready = 1'b0;
        seg(1'b1, 250); seg(1'b0, 750);
        hs_flag = 1;
        model_edge(1'b1, 250);
        hs_flag = 0;
        expc = last_push;
        pwm = 1'b1;
        wait_cyc(5);
        chk("hs_old_valid", 32'(tvalid), 32'd1);
        tready = 1'b1;
        wait_cyc(1);
        chk("hs_new_valid", 32'(tvalid), 32'd1);
        chk("hs_new_data", tdata, expc);
        chk("hs_no_overrun", 32'(ov), 32'd0);
        wait_cyc(244);
        seg(1'b0, 750);
        chk("hs_overrun_total", 32'(ov_seen), 32'(exp_ov));

        // Reset mid-high-time with a stalled beat pending
        tready = 1'b0;
        seg(1'b1, 100);
        chk("prerst_valid", 32'(tvalid), 32'd1);
        rstn = 1'b0;
        @(negedge clk);
        rstn = 1'b1;
        model_reset();
        chk("midrst_tdata", tdata, 32'd0);
        chk("midrst_tvalid", 32'(tvalid), 32'd0);
        chk("midrst_level", 32'(lvl_o), 32'd0);
        chk("midrst_timeout", 32'(to_o), 32'd0);
        chk("midrst_overrun", 32'(ov), 32'd0);
        tready = 1'b1;
        b0 = beats;
        seg(1'b1, 2); seg(1'b0, 750);
        seg(1'b1, 250); seg(1'b0, 750);
        chk("midrst_no_early_beat", 32'(beats - b0), 32'd0);
        seg(1'b1, 250); seg(1'b0, 750);
        chk("midrst_second_rise_beat", 32'(beats - b0), 32'd1);

        wait_cyc(20);
        chk("queue_drained", 32'(expq.size()), 32'd0);
        chk("overrun_total", 32'(ov_seen), 32'(exp_ov));
        chk("inv_overrun_total", 32'(inv_ov_seen), 32'(exp_ov));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/pwm_capture.md
# pwm_capture

Single-channel PWM decoder: measures the period and active-time of an external PWM waveform (e.g. a magnetic encoder's PWM angle output, or a loop-back of a generated PWM phase) and streams each completed measurement as an AXI-Stream beat. It is the receive side of the team's PWM generation path: where the generator turns compare values into edges, this block turns edges back into counts. Downstream consumers (angle scaling, duty monitor) take `{high, period}` samples at one per PWM period.

## Interface
- `CNT_WIDTH`, 16, width of the period and high-time counters.
- `FILTER_LEN`, 3, consecutive equal samples required to accept a level change (≥1).
- `TIMEOUT`, 16'hFFFF, cycles without a rising edge before timeout; must be ≤ 2^CNT_WIDTH−1.
- `INPUT_ACTIVE_LEVEL`, 1, the `pwm_in` level counted as "high".

Ports:
- `clk` in 1, clock.
- `rstn` in 1, reset, synchronous, active-low.
- `pwm_in` in 1, asynchronous PWM input.
- `m_axis_tdata` out 2*CNT_WIDTH, `{high_cnt, period_cnt}`; high_cnt is in the upper half.
- `m_axis_tvalid` out 1, sample valid.
- `m_axis_tready` in 1, consumer ready.
- `level_out` out 1, filtered, active-normalized input level.
- `timeout` out 1, level; set while no rising edge is seen for `TIMEOUT` cycles.
- `overrun` out 1, one-cycle pulse when a sample is dropped.

## Operation
- Input path:
  - `pwm_in` passes through a 2-FF synchronizer and is XORed with `INPUT_ACTIVE_LEVEL==0` to give `act`.
  - Glitch filter: filtered level `lvl` takes a new value only after `FILTER_LEN` consecutive `act` samples that differ from `lvl`. Any mismatch restarts the run count.
  - Synchronizer and filter reset to inactive (`act`=0).
  - `level_out` = `lvl`.
- Edge detect: `rise` = `lvl` & ~`lvl_d`; `fall` = ~`lvl` & `lvl_d`.
- State machine, two states:
  - IDLE (the reset state) to MEASURE on `rise`. Load `p_cnt`=1, `h_cnt`=1, `fall_seen`=0, and clear `timeout`. No sample is emitted.
  - In MEASURE, each cycle without an edge: `p_cnt`+=1. `h_cnt`+=1 only while `fall_seen`=0.
  - In MEASURE on `fall`: latch `h_lat`=`h_cnt`, set `fall_seen`=1.
  - In MEASURE on `rise` with `fall_seen`=1: emit sample `{h_lat, p_cnt}`, then reload as on entry. `rise` with `fall_seen`=0 cannot occur after filtering; treat it as a reload with no emit.
  - MEASURE to IDLE when `p_cnt` == `TIMEOUT` with no `rise` that cycle. Set `timeout`=1; no sample. `level_out` tells stuck-high from stuck-low.
- Resulting counts: a rising edge at filtered cycle 0, falling at F, and next rising at T yields high=F, period=T exactly.
- Output register (AXIS master, tdata stable while tvalid):
  - Emit when `m_axis_tvalid`=0 or `m_axis_tready`=1: load tdata, tvalid=1.
  - Emit when `m_axis_tvalid`=1 and `m_axis_tready`=0: drop the sample, pulse `overrun`, tdata unchanged.
  - Handshake with no emit: tvalid=0.
  - Handshake and emit in the same cycle: the old beat is accepted, the new beat is loaded, tvalid stays 1, no overrun.

## Timing
- Reset values: `m_axis_tdata`=0, `m_axis_tvalid`=0, `level_out`=0, `timeout`=0, `overrun`=0. State is IDLE and all counters are 0.
- Pin-to-`lvl` latency is 2 + `FILTER_LEN` cycles. `rise`/`fall` are asserted in the cycle `lvl` changes.
- `m_axis_tvalid` and new `m_axis_tdata` appear 1 cycle after the `rise` cycle. `overrun` pulses in that same cycle.
- `timeout` asserts the cycle after `p_cnt` reaches `TIMEOUT`. It deasserts the cycle after the next `rise`.
- The first full period after reset or after a timeout is never reported. The first sample arrives on the second rising edge.
- Reset mid-period: everything returns to reset values next cycle. A pending tvalid is dropped and the partial measurement is discarded.
- Constant 0 % or 100 % duty produces no samples; only `timeout` and `level_out` report it.

## Test plan
- Basic measurement, defaults: drive period 1000 cycles with 250 high for 5 periods → 4 beats, each tdata = {16'd250, 16'd1000}. tready is held 1. The first beat's tvalid rises (2+3)+1 cycles after the pin's second rising edge.
- Glitch filter: insert 2-cycle low glitches during high time → results are unchanged. A 3-cycle glitch is accepted and corrupts the high count, as expected. `INPUT_ACTIVE_LEVEL`=0 with the inverted waveform gives the same {250,1000}.
- Timeout: `TIMEOUT`=4096; hold the pin high after a rising edge → `timeout`=1 exactly 4096 cycles after `rise`, `level_out`=1, no beat. Resume the PWM → `timeout` clears on the first rise, and the first beat arrives one full period later.
- Backpressure: hold tready=0 across two periods → first beat held stable, second dropped with a 1-cycle `overrun`. Raise tready → beat accepted and tvalid drops.
- Simultaneous handshake: assert tready exactly in the emit cycle → old beat accepted, new beat loaded, tvalid continuous, no overrun.
- Reset mid-operation: assert rstn=0 for 1 cycle mid-high-time with tvalid=1 → all outputs 0 next cycle. No beat until the second subsequent rising edge.
